// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end: instruction width, PC step,
// the bubble instruction and the layout of one prefetched entry.
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_INC = 4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc4;
  } fetch_entry_t;
endpackage

// File: rtl/mips_sync_fifo.sv
// Synchronous FIFO with registered storage, head read-out and a synchronous flush.
// Pointers wrap modulo DEPTH; pushes into a full FIFO and pops from an empty one are ignored.
module mips_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full,
  output logic [CW-1:0]    o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    o_empty = (r_count == '0);
    o_full  = (r_count == CW'(DEPTH));
    w_pop   = i_pop && !o_empty;
    w_push  = i_push && !o_full;
    o_head  = r_mem[r_rd_ptr];
    o_count = r_count;
  end

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end
endmodule

// File: rtl/mips_fetch_queue.sv
// Instruction-fetch front end: PC generator, pipelined in-order memory interface
// with several requests in flight, and a prefetch queue feeding IF/ID.
module mips_fetch_queue
  import mips_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  localparam int             OW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               dec_valid,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [XLEN-1:0]    dec_pc4,
  input  logic               dec_ready,
  output logic [OW-1:0]      outstanding
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int QW = INSTR_W + XLEN;

  logic [XLEN-1:0] r_fetch_pc;
  logic [OW-1:0]   r_out;
  logic [OW-1:0]   r_drop;

  logic            w_rsp, w_accept, w_enq, w_deq;
  logic [OW-1:0]   w_out_next;
  logic [XLEN-1:0] w_redirect_pc;
  logic [QW-1:0]   w_q_head;
  logic            w_q_empty, w_q_full;
  logic [CW-1:0]   w_q_count;
  logic [XLEN-1:0] w_pc_head;
  logic            w_pc_empty, w_pc_full;
  logic [OW-1:0]   w_pc_count;

  // Both interfaces use valid/ready: a transfer happens on a cycle where valid && ready;
  // a held request keeps addr/valid stable until accepted or withdrawn by a redirect.
  always_comb begin
    imem_req_valid = !reset && !redirect_valid
                     && ((int'(w_q_count) + int'(r_out)) < DEPTH)
                     && (int'(r_out) < MAX_OUTSTANDING);
    imem_req_addr  = r_fetch_pc;
    w_accept       = imem_req_valid && imem_req_ready;
    w_rsp          = imem_rsp_valid && !reset;
    // Responses during a redirect, or owed to an older redirect, are wrong-path.
    w_enq          = w_rsp && !redirect_valid && (r_drop == '0);
    dec_valid      = !reset && !w_q_empty;
    dec_instr      = dec_valid ? w_q_head[QW-1:XLEN] : NOP_INSTR;
    dec_pc4        = w_q_head[XLEN-1:0];
    w_deq          = dec_valid && dec_ready;
    outstanding    = r_out;
    w_redirect_pc  = redirect_pc & ~XLEN'(3);
    w_out_next     = r_out;
    if (w_accept && !w_rsp)      w_out_next = r_out + OW'(1);
    else if (!w_accept && w_rsp) w_out_next = r_out - OW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_out      <= '0;
      r_drop     <= '0;
    end else begin
      r_out <= w_out_next;
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
        r_drop     <= w_out_next;
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + XLEN'(PC_INC);
        if (w_rsp && (r_drop != '0)) r_drop <= r_drop - OW'(1);
      end
    end
  end

  // Request PCs in issue order; every response, kept or dropped, retires one.
  mips_sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_pc_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (1'b0),
    .i_push     (w_accept),
    .i_push_data(r_fetch_pc),
    .i_pop      (w_rsp),
    .o_head     (w_pc_head),
    .o_empty    (w_pc_empty),
    .o_full     (w_pc_full),
    .o_count    (w_pc_count)
  );

  mips_sync_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_prefetch_q (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (redirect_valid),
    .i_push     (w_enq),
    .i_push_data({imem_rsp_data, w_pc_head + XLEN'(PC_INC)}),
    .i_pop      (w_deq),
    .o_head     (w_q_head),
    .o_empty    (w_q_empty),
    .o_full     (w_q_full),
    .o_count    (w_q_count)
  );

  a_no_overflow:   assert property (@(posedge clk) disable iff (reset) !(w_enq && w_q_full));
  a_rsp_has_req:   assert property (@(posedge clk) disable iff (reset) !(w_rsp && w_pc_empty));
  a_pc_fifo_room:  assert property (@(posedge clk) disable iff (reset) !(w_accept && w_pc_full));
  a_pc_fifo_track: assert property (@(posedge clk) disable iff (reset) w_pc_count == r_out);
endmodule

// File: tb/tb_mips_fetch_queue.sv
// Bench for mips_fetch_queue: in-order memory model with programmable latency and
// stall, a queue-based reference model compared every cycle, and directed scenarios.
module tb_mips_fetch_queue;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc4;
  logic        dec_ready;
  logic [1:0]  outstanding;

  always #5 clk = ~clk;

  mips_fetch_queue #(
    .XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .dec_valid(dec_valid), .dec_instr(dec_instr),
    .dec_pc4(dec_pc4), .dec_ready(dec_ready), .outstanding(outstanding)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] exp_q[$];   // {instr, pc4} the decoder must see, head first
  logic [31:0] m_pcq[$];   // addresses of requests still owed a response
  logic [31:0] m_pc;
  int          m_out;
  int          m_drop;
  bit          model_live = 1'b0;

  function automatic logic exp_req_valid();
    return !reset && !redirect_valid && ((exp_q.size() + m_out) < DEPTH) && (m_out < MAXO);
  endfunction

  always @(posedge clk) begin
    logic        acc, dv;
    logic [31:0] a;
    if (reset) begin
      m_pc = RESET_PC; m_out = 0; m_drop = 0;
      exp_q.delete(); m_pcq.delete();
      model_live = 1'b1;
    end else if (model_live) begin
      acc = exp_req_valid() && imem_req_ready;
      dv  = exp_q.size() > 0;
      if (acc) begin
        m_pcq.push_back(m_pc);
        m_pc = m_pc + 32'd4;
        m_out++;
      end
      if (imem_rsp_valid && m_pcq.size() > 0) begin
        a = m_pcq.pop_front();
        m_out--;
        if (!redirect_valid) begin
          if (m_drop > 0) m_drop--;
          else exp_q.push_back({imem_rsp_data, a + 32'd4});
        end
      end
      if (dv && dec_ready) void'(exp_q.pop_front());
      if (redirect_valid) begin
        exp_q.delete();
        m_pc   = {redirect_pc[31:2], 2'b00};
        m_drop = m_out;
      end
    end
  end

  // Single compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic ev, dv;
    if (model_live) begin
      ev = exp_req_valid();
      dv = !reset && (exp_q.size() > 0);
      chk("req_valid", 32'(imem_req_valid), 32'(ev));
      if (ev) chk("req_addr", imem_req_addr, m_pc);
      chk("dec_valid", 32'(dec_valid), 32'(dv));
      if (dv) begin
        chk("dec_instr", dec_instr, exp_q[0][63:32]);
        chk("dec_pc4", dec_pc4, exp_q[0][31:0]);
      end
      chk("outstanding", 32'(outstanding), 32'(m_out));
    end
  end

  // ---------------- memory model and cycle driver ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  int          mem_lat = 1;
  int          cyc = 0;
  logic        s_req_valid, s_dec_valid;
  logic [31:0] s_req_addr, s_dec_pc4;
  logic [1:0]  s_out;
  logic [31:0] acc_log[$];
  logic [31:0] dec_log[$];
  logic [31:0] ins_log[$];

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic step();
    logic  acc;
    mreq_t m;
    if (!reset && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~mem_q[0].addr;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    @(negedge clk);
    s_req_valid = imem_req_valid; s_req_addr = imem_req_addr;
    s_dec_valid = dec_valid;      s_dec_pc4  = dec_pc4;
    s_out       = outstanding;
    acc = imem_req_valid && imem_req_ready && !reset;
    if (acc) acc_log.push_back(imem_req_addr);
    if (dec_valid && dec_ready) begin
      dec_log.push_back(dec_pc4);
      ins_log.push_back(dec_instr);
    end
    m.addr = imem_req_addr;
    m.due  = cyc + mem_lat;
    @(posedge clk);
    #1;
    if (reset) mem_q.delete();
    else begin
      if (imem_rsp_valid) void'(mem_q.pop_front());
      if (acc) mem_q.push_back(m);
    end
    cyc++;
  endtask

  task automatic clear_logs();
    acc_log.delete(); dec_log.delete(); ins_log.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    step();
    chk("reset_req_valid", 32'(s_req_valid), 32'd0);
    chk("reset_dec_valid", 32'(s_dec_valid), 32'd0);
    step();
    reset = 1'b0;
    clear_logs();
  endtask

  initial begin
    bit f200, f300;
    reset = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b1;

    // 1: streaming, 1-cycle memory
    do_reset(); mem_lat = 1; imem_req_ready = 1'b1; dec_ready = 1'b1;
    step();
    chk("t1_c0_req_valid", 32'(s_req_valid), 32'd1);
    chk("t1_c0_req_addr", s_req_addr, 32'h0);
    chk("t1_c0_out", 32'(s_out), 32'd0);
    step();
    chk("t1_c1_req_addr", s_req_addr, 32'h4);
    chk("t1_c1_dec_valid", 32'(s_dec_valid), 32'd0);
    step();
    chk("t1_c2_dec_valid", 32'(s_dec_valid), 32'd1);
    chk("t1_c2_dec_pc4", s_dec_pc4, 32'h4);
    repeat (6) step();
    chk("t1_rate", 32'(dec_log.size()), 32'd7);
    chk("t1_pc4_1", qget(dec_log, 1), 32'h8);
    chk("t1_pc4_2", qget(dec_log, 2), 32'hC);
    chk("t1_instr_0", qget(ins_log, 0), ~32'h0);
    chk("t1_acc_2", qget(acc_log, 2), 32'h8);

    // 2: back-pressure fills the queue, then drains in order
    do_reset(); mem_lat = 1; dec_ready = 1'b0;
    repeat (8) step();
    chk("t2_req_count", 32'(acc_log.size()), 32'd4);
    chk("t2_req_last", qget(acc_log, 3), 32'hC);
    chk("t2_req_stopped", 32'(s_req_valid), 32'd0);
    dec_ready = 1'b1;
    repeat (6) step();
    chk("t2_drain_0", qget(dec_log, 0), 32'h4);
    chk("t2_drain_3", qget(dec_log, 3), 32'h10);
    chk("t2_drain_4", qget(dec_log, 4), 32'h14);
    chk("t2_resume", qget(acc_log, 4), 32'h10);

    // 3: redirect with two requests in flight
    do_reset(); mem_lat = 4; dec_ready = 1'b1;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    chk("t3_inflight", 32'(s_out), 32'd2);
    chk("t3_no_req", 32'(s_req_valid), 32'd0);
    redirect_valid = 1'b0;
    repeat (10) step();
    chk("t3_new_req", qget(acc_log, 2), 32'h100);
    chk("t3_first_pc4", qget(dec_log, 0), 32'h104);
    chk("t3_first_instr", qget(ins_log, 0), ~32'h100);

    // 4: redirect in the same cycle as the only response; low target bits ignored
    do_reset(); mem_lat = 2; dec_ready = 1'b1; imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    step();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    step();
    chk("t4_req_valid", 32'(s_req_valid), 32'd1);
    chk("t4_req_addr", s_req_addr, 32'h40);
    chk("t4_out", 32'(s_out), 32'd0);
    repeat (5) step();
    chk("t4_first_pc4", qget(dec_log, 0), 32'h44);

    // 5: memory stall holds the request
    do_reset(); mem_lat = 1; dec_ready = 1'b1; imem_req_ready = 1'b1;
    step(); step();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_hold_valid", 32'(s_req_valid), 32'd1);
      chk("t5_hold_addr", s_req_addr, 32'h8);
    end
    imem_req_ready = 1'b1;
    step(); step();
    chk("t5_resume_addr", s_req_addr, 32'hC);
    chk("t5_acc_2", qget(acc_log, 2), 32'h8);

    // 6: reset with queued entries and two in flight
    do_reset(); mem_lat = 3; dec_ready = 1'b0;
    repeat (6) step();
    chk("t6_pre_dec_valid", 32'(s_dec_valid), 32'd1);
    reset = 1'b1;
    step();
    chk("t6_rst_out", 32'(s_out), 32'd2);
    chk("t6_rst_dec_valid", 32'(s_dec_valid), 32'd0);
    chk("t6_rst_req_valid", 32'(s_req_valid), 32'd0);
    reset = 1'b0; clear_logs();
    step();
    chk("t6_dec_valid", 32'(s_dec_valid), 32'd0);
    chk("t6_out", 32'(s_out), 32'd0);
    chk("t6_req_addr", s_req_addr, RESET_PC);
    repeat (8) step();

    // 7: mixed stalls with back-to-back redirects, model-checked every cycle
    do_reset(); mem_lat = 2;
    for (int i = 0; i < 40; i++) begin
      dec_ready      = (i % 3) != 0;
      imem_req_ready = (i % 5) != 1;
      redirect_valid = (i == 17) || (i == 18);
      redirect_pc    = (i == 17) ? 32'h200 : 32'h302;
      step();
    end
    redirect_valid = 1'b0; dec_ready = 1'b1; imem_req_ready = 1'b1;
    repeat (10) step();
    f200 = 1'b0; f300 = 1'b0;
    foreach (acc_log[k]) begin
      if (acc_log[k] == 32'h200) f200 = 1'b1;
      if (acc_log[k] == 32'h300) f300 = 1'b1;
    end
    chk("t7_first_redirect_lost", 32'(f200), 32'd0);
    chk("t7_last_redirect_wins", 32'(f300), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
